e_mdu: RTL

- Execute-stage multiply/divide unit. Sits alongside the E-stage ALU and receives the same forwarded SrcA/SrcB operands.
- Owns the HI/LO architectural registers. Executes mult/multu/div/divu/mthi/mtlo/mfhi/mflo with fixed multi-cycle latency.
- Exposes Start/Busy so hazard control can stall any MDU instruction in D while an operation is outstanding.
- MDU_Result is muxed with ALU_Result into the E/M pipeline register.

---
 rtl/e_mdu.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/e_mdu.sv
// e_mdu: E-stage multiply/divide unit owning HI/LO; madd/maddu enabled by `define MDU_MADD_EN.
// Latency: MULT_CYCLES or DIV_CYCLES busy cycles; new HI/LO readable the cycle after Busy drops.
// Backpressure: none inside; Start/Busy let hazard control stall later MDU ops in D.
module e_mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] SrcA,
  input  logic [31:0] SrcB,
  input  logic [3:0]  MDU_Ctr,
  input  logic        Req,
  output logic        Start,
  output logic        Busy,
  output logic [31:0] HI_Out,
  output logic [31:0] LO_Out,
  output logic [31:0] MDU_Result
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MFHI  = 4'd7;
  localparam logic [3:0] OP_MFLO  = 4'd8;
`ifdef MDU_MADD_EN
  localparam logic [3:0] OP_MADD  = 4'd9;
  localparam logic [3:0] OP_MADDU = 4'd10;
`endif

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAX_CYCLES + 1);

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
  } hilo_t;

  hilo_t         hilo_q;
  hilo_t         pend_q;
  hilo_t         pend_d;
  logic          pend_wr_q;
  logic          pend_wr_d;
  logic [CW-1:0] cnt_q;

  logic          is_mul;
  logic          is_div;
  logic          is_madd;
  logic          mul_signed;
  logic          start_go;

  logic [63:0]   mul_a;
  logic [63:0]   mul_b;
  logic [63:0]   mul_p;

  logic          a_neg;
  logic          b_neg;
  logic [31:0]   a_mag;
  logic [31:0]   b_mag;
  logic [31:0]   divisor;
  logic [31:0]   q_mag;
  logic [31:0]   r_mag;
  logic [31:0]   quot;
  logic [31:0]   rem;

  always_comb begin
    is_mul     = (MDU_Ctr == OP_MULT) || (MDU_Ctr == OP_MULTU);
    is_div     = (MDU_Ctr == OP_DIV) || (MDU_Ctr == OP_DIVU);
    mul_signed = (MDU_Ctr == OP_MULT);
    is_madd    = 1'b0;
`ifdef MDU_MADD_EN
    mul_signed = mul_signed || (MDU_Ctr == OP_MADD);
    is_madd    = (MDU_Ctr == OP_MADD) || (MDU_Ctr == OP_MADDU);
`endif
  end

  assign Start    = (is_mul || is_div || is_madd) && !Req;
  assign start_go = Start && !Busy;

  // One 64-bit multiplier serves both signednesses: the low 64 bits of a product
  // of sign-extended operands equal the signed 32x32 product.
  assign mul_a = {{32{mul_signed & SrcA[31]}}, SrcA};
  assign mul_b = {{32{mul_signed & SrcB[31]}}, SrcB};
  assign mul_p = mul_a * mul_b;

  // Signed divide via magnitudes: quotient truncates toward zero, remainder takes
  // the dividend's sign; 0x80000000 / -1 falls out as 0x80000000 rem 0.
  always_comb begin
    a_neg   = (MDU_Ctr == OP_DIV) && SrcA[31];
    b_neg   = (MDU_Ctr == OP_DIV) && SrcB[31];
    a_mag   = a_neg ? (32'd0 - SrcA) : SrcA;
    b_mag   = b_neg ? (32'd0 - SrcB) : SrcB;
    divisor = (SrcB == 32'd0) ? 32'd1 : b_mag;
    q_mag   = a_mag / divisor;
    r_mag   = a_mag % divisor;
    quot    = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
    rem     = a_neg ? (32'd0 - r_mag) : r_mag;
  end

  always_comb begin
    pend_d    = hilo_t'(mul_p);
    pend_wr_d = 1'b1;
    if (is_div) begin
      pend_d    = hilo_t'({rem, quot});
      pend_wr_d = (SrcB != 32'd0);
    end
`ifdef MDU_MADD_EN
    else if (is_madd) begin
      pend_d = hilo_t'({hilo_q.hi, hilo_q.lo} + mul_p);
    end
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hilo_q    <= '0;
      pend_q    <= '0;
      pend_wr_q <= 1'b0;
      cnt_q     <= '0;
      Busy      <= 1'b0;
    end else if (Busy) begin
      if (cnt_q == CW'(1)) begin
        Busy  <= 1'b0;
        cnt_q <= '0;
        if (pend_wr_q) begin
          hilo_q <= pend_q;
        end
      end else begin
        cnt_q <= cnt_q - CW'(1);
      end
    end else if (start_go) begin
      pend_q    <= pend_d;
      pend_wr_q <= pend_wr_d;
      cnt_q     <= is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
      Busy      <= 1'b1;
    end else if (!Req) begin
      if (MDU_Ctr == OP_MTHI) begin
        hilo_q.hi <= SrcA;
      end
      if (MDU_Ctr == OP_MTLO) begin
        hilo_q.lo <= SrcA;
      end
    end
  end

  assign HI_Out = hilo_q.hi;
  assign LO_Out = hilo_q.lo;

  always_comb begin
    MDU_Result = '0;
    if (MDU_Ctr == OP_MFHI) begin
      MDU_Result = hilo_q.hi;
    end else if (MDU_Ctr == OP_MFLO) begin
      MDU_Result = hilo_q.lo;
    end
  end

endmodule
